systolic_array_feeder: RTL and testbench



---
 rtl/systolic_array_feeder.sv | 241 ++++++++++++++++++++++++
 tb/tb_systolic_array_feeder.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_feeder.sv
// ---------------------------------------------------------------------------
// systolic_array_feeder
//
// Transmit-side edge driver for a weight-stationary systolic array. One tile
// at a time it clears the PE weights, shifts ROWS weight rows down through the
// columns, streams activation vectors into the rows, then flushes the array
// while emitting per-column valid tags for the bottom-row result collector.
//
// Optional feature macro: SYSTOLIC_FEEDER_SKEW_EN
//   defined     : row r is delayed by r extra cycles (registered psum path)
//   not defined : all rows presented together, no skew registers built
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start, num_vec    tile start pulse (IDLE only) and vector count
//   wet_*             weight-row handshake, column c at [c*BW_WET +: BW_WET]
//   act_*             activation-vector handshake, row r at [r*BW_ACT +: BW_ACT]
//   arr_clear_weight  clear all PE weights
//   arr_load_weight   array shifts weights down one row
//   arr_mac_enable    PEs accumulate
//   arr_above_out     top-edge input per column (sign-extended weight or 0)
//   arr_act_out       left-edge activation per row
//   col_valid_out     bottom-row result of column c is a real vector
//   busy, done        tile in progress / one-cycle end-of-tile pulse
// All outputs are registered.
// ---------------------------------------------------------------------------
module systolic_array_feeder #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int BW_ACT  = 8,
    parameter int BW_WET  = 8,
    parameter int BW_ACCU = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [15:0]             num_vec,
    input  logic                    wet_valid,
    output logic                    wet_ready,
    input  logic [COLS*BW_WET-1:0]  wet_data,
    input  logic                    act_valid,
    output logic                    act_ready,
    input  logic [ROWS*BW_ACT-1:0]  act_data,
    output logic                    arr_clear_weight,
    output logic                    arr_load_weight,
    output logic                    arr_mac_enable,
    output logic [COLS*BW_ACCU-1:0] arr_above_out,
    output logic [ROWS*BW_ACT-1:0]  arr_act_out,
    output logic [COLS-1:0]         col_valid_out,
    output logic                    busy,
    output logic                    done
);

`ifdef SYSTOLIC_FEEDER_SKEW_EN
    localparam int K = 1;
`else
    localparam int K = 0;
`endif
    // Flush length equals the depth of the tag pipeline, so the last valid
    // tag has left col_valid_out before done.
    localparam int D   = K * (ROWS - 1) + COLS;
    localparam int RCW = $clog2(ROWS + 1);
    localparam int FCW = $clog2(D + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [RCW-1:0] r_row_cnt;
    logic [15:0]    r_vec_cnt;
    logic [15:0]    r_num_vec;
    logic [FCW-1:0] r_flush_cnt;

    logic w_wet_acc;
    logic w_act_acc;

    // Output registers and their next-state values.
    logic r_clear, r_load, r_mac, r_busy, r_done, r_wet_ready, r_act_ready;
    logic w_clear_nxt, w_load_nxt, w_mac_nxt, w_busy_nxt, w_done_nxt;
    logic w_wet_ready_nxt, w_act_ready_nxt;
    logic [COLS*BW_ACCU-1:0] r_above;
    logic [COLS*BW_ACCU-1:0] w_above_nxt;
    logic [ROWS*BW_ACT-1:0]  w_inj;
    logic [D-1:0]            r_tag;

    // Ready is registered and high exactly while in the matching state, so
    // the state test is the handshake.
    assign w_wet_acc = wet_valid && (r_state == S_LOAD);
    assign w_act_acc = act_valid && (r_state == S_STREAM);

    // ---------------- state register (plus tile counters) ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_row_cnt   <= '0;
            r_vec_cnt   <= '0;
            r_num_vec   <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_IDLE && start)
                r_num_vec <= num_vec;

            if (r_state == S_CLEAR)
                r_row_cnt <= '0;
            else if (w_wet_acc)
                r_row_cnt <= r_row_cnt + RCW'(1);

            if (r_state == S_LOAD)
                r_vec_cnt <= '0;
            else if (w_act_acc)
                r_vec_cnt <= r_vec_cnt + 16'd1;

            if (r_state == S_FLUSH)
                r_flush_cnt <= r_flush_cnt + FCW'(1);
            else
                r_flush_cnt <= '0;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every combinational output gets a default first, otherwise a path
    // that skips the assignment infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_CLEAR;
            S_CLEAR:  w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_wet_acc && r_row_cnt == RCW'(ROWS - 1))
                    w_state_nxt = (r_num_vec == 16'd0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (w_act_acc && r_vec_cnt == r_num_vec - 16'd1)
                    w_state_nxt = S_FLUSH;
            end
            S_FLUSH:  if (r_flush_cnt == FCW'(D - 1)) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // Control outputs follow the state they describe; the data path (load
    // strobe, above data, activations, tags) appears the cycle after its
    // accept. The last weight beat therefore shows on the first STREAM cycle;
    // that cycle carries only a zero activation tagged invalid, so the
    // collector ignores whatever it produces.
    always_comb begin
        w_clear_nxt     = (w_state_nxt == S_CLEAR);
        w_wet_ready_nxt = (w_state_nxt == S_LOAD);
        w_act_ready_nxt = (w_state_nxt == S_STREAM);
        w_mac_nxt       = (w_state_nxt == S_STREAM) || (w_state_nxt == S_FLUSH);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_done_nxt      = (w_state_nxt == S_DONE);
        w_load_nxt      = w_wet_acc;
        w_above_nxt     = '0;
        if (w_wet_acc) begin
            for (int c = 0; c < COLS; c++) begin
                w_above_nxt[c*BW_ACCU +: BW_ACCU] =
                    {{(BW_ACCU - BW_WET){wet_data[c*BW_WET + BW_WET - 1]}},
                     wet_data[c*BW_WET +: BW_WET]};
            end
        end
        // Cycles without an accepted vector inject an all-zero bubble.
        w_inj = w_act_acc ? act_data : '0;
    end

    // ---------------- output registers and tag pipeline ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clear     <= 1'b0;
            r_load      <= 1'b0;
            r_mac       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wet_ready <= 1'b0;
            r_act_ready <= 1'b0;
            r_above     <= '0;
            r_tag       <= '0;
        end else begin
            r_clear     <= w_clear_nxt;
            r_load      <= w_load_nxt;
            r_mac       <= w_mac_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_wet_ready <= w_wet_ready_nxt;
            r_act_ready <= w_act_ready_nxt;
            r_above     <= w_above_nxt;
            // Tag bit i is the vector-valid flag from i+1 cycles ago.
            r_tag       <= (r_tag << 1) | D'(w_act_acc);
        end
    end

    // Column c sees the bottom-row result after the row skew plus c hops.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign col_valid_out[c] = r_tag[K*(ROWS-1) + c];
    end

    // Per-row activation delay line: stage 0 is the output register, plus
    // r skew stages when skew is enabled.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [BW_ACT-1:0] r_pipe [0:K*r];

        // NOTE: the skew stages are reset like any other register so an
        // abandoned tile leaves no stale activations in flight.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i <= K*r; i++)
                    r_pipe[i] <= '0;
            end else begin
                r_pipe[0] <= w_inj[r*BW_ACT +: BW_ACT];
                for (int i = 1; i <= K*r; i++)
                    r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign arr_act_out[r*BW_ACT +: BW_ACT] = r_pipe[K*r];
    end

    assign arr_clear_weight = r_clear;
    assign arr_load_weight  = r_load;
    assign arr_mac_enable   = r_mac;
    assign arr_above_out    = r_above;
    assign busy             = r_busy;
    assign done             = r_done;
    assign wet_ready        = r_wet_ready;
    assign act_ready        = r_act_ready;

endmodule

// File: tb/tb_systolic_array_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_array_feeder
//
// Self-checking bench for systolic_array_feeder (ROWS=COLS=4, 8-bit data,
// 32-bit partial sums). A cycle-indexed model turns each handshake seen on
// the inputs into expected outputs at absolute future cycles; a compare
// process checks every output on every negedge. Directed tiles then pin the
// model with hand-computed literals. Follows SYSTOLIC_FEEDER_SKEW_EN.
// ---------------------------------------------------------------------------
module tb_systolic_array_feeder;

    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int BW_ACT  = 8;
    localparam int BW_WET  = 8;
    localparam int BW_ACCU = 32;
`ifdef SYSTOLIC_FEEDER_SKEW_EN
    localparam int K = 1;
`else
    localparam int K = 0;
`endif
    localparam int D    = K * (ROWS - 1) + COLS;
    localparam int NCYC = 1024;

    localparam int P_IDLE   = 0;
    localparam int P_CLEAR  = 1;
    localparam int P_LOAD   = 2;
    localparam int P_STREAM = 3;
    localparam int P_FLUSH  = 4;
    localparam int P_DONE   = 5;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic [15:0]             num_vec = '0;
    logic                    wet_valid = 1'b0;
    logic                    wet_ready;
    logic [COLS*BW_WET-1:0]  wet_data = '0;
    logic                    act_valid = 1'b0;
    logic                    act_ready;
    logic [ROWS*BW_ACT-1:0]  act_data = '0;
    logic                    arr_clear_weight;
    logic                    arr_load_weight;
    logic                    arr_mac_enable;
    logic [COLS*BW_ACCU-1:0] arr_above_out;
    logic [ROWS*BW_ACT-1:0]  arr_act_out;
    logic [COLS-1:0]         col_valid_out;
    logic                    busy;
    logic                    done;

    systolic_array_feeder #(
        .ROWS(ROWS), .COLS(COLS), .BW_ACT(BW_ACT), .BW_WET(BW_WET), .BW_ACCU(BW_ACCU)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
        .wet_valid(wet_valid), .wet_ready(wet_ready), .wet_data(wet_data),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .arr_clear_weight(arr_clear_weight), .arr_load_weight(arr_load_weight),
        .arr_mac_enable(arr_mac_enable), .arr_above_out(arr_above_out),
        .arr_act_out(arr_act_out), .col_valid_out(col_valid_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs per absolute cycle.
    int                      exp_ph    [NCYC];
    logic                    exp_load  [NCYC];
    logic [COLS*BW_ACCU-1:0] exp_above [NCYC];
    logic [ROWS*BW_ACT-1:0]  exp_act   [NCYC];
    logic [COLS-1:0]         exp_colv  [NCYC];

    // Recorded DUT outputs per cycle, for the literal checks.
    logic                    tr_load  [NCYC];
    logic                    tr_mac   [NCYC];
    logic                    tr_clear [NCYC];
    logic                    tr_busy  [NCYC];
    logic                    tr_done  [NCYC];
    logic [COLS*BW_ACCU-1:0] tr_above [NCYC];
    logic [ROWS*BW_ACT-1:0]  tr_act   [NCYC];
    logic [COLS-1:0]         tr_colv  [NCYC];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model ----------------
    initial begin
        int ph, nxt, rows, vecs, fl, n;
        logic [15:0] nv;
        logic [7:0]  b;
        for (int i = 0; i < NCYC; i++) begin
            exp_ph[i] = P_IDLE; exp_load[i] = 1'b0; exp_above[i] = '0;
            exp_act[i] = '0; exp_colv[i] = '0;
        end
        ph = P_IDLE; rows = 0; vecs = 0; fl = 0; nv = '0;
        forever begin
            @(posedge clk);
            n = cyc;
            if (n + 16 < NCYC) begin
                nxt = ph;
                if (reset) begin
                    nxt = P_IDLE; rows = 0; vecs = 0; fl = 0;
                    for (int i = n + 1; i < n + 16; i++) begin
                        exp_load[i] = 1'b0; exp_above[i] = '0;
                        exp_act[i] = '0; exp_colv[i] = '0;
                    end
                end else begin
                    case (ph)
                        P_IDLE: if (start) begin nv = num_vec; nxt = P_CLEAR; end
                        P_CLEAR: begin rows = 0; nxt = P_LOAD; end
                        P_LOAD: if (wet_valid) begin
                            exp_load[n+1] = 1'b1;
                            for (int c = 0; c < COLS; c++) begin
                                b = wet_data[c*BW_WET +: BW_WET];
                                exp_above[n+1][c*BW_ACCU +: BW_ACCU] = int'($signed(b));
                            end
                            rows++;
                            if (rows == ROWS) begin
                                vecs = 0;
                                nxt = (nv == 0) ? P_DONE : P_STREAM;
                            end
                        end
                        P_STREAM: if (act_valid) begin
                            for (int r = 0; r < ROWS; r++)
                                exp_act[n+1+K*r][r*BW_ACT +: BW_ACT] = act_data[r*BW_ACT +: BW_ACT];
                            for (int c = 0; c < COLS; c++)
                                exp_colv[n+1+K*(ROWS-1)+c][c] = 1'b1;
                            vecs++;
                            if (vecs == int'(nv)) begin fl = 0; nxt = P_FLUSH; end
                        end
                        P_FLUSH: begin fl++; if (fl == D) nxt = P_DONE; end
                        P_DONE: nxt = P_IDLE;
                        default: nxt = P_IDLE;
                    endcase
                end
                ph = nxt;
                exp_ph[n+1] = nxt;
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        int n, e_ph;
        logic e_load;
        logic [COLS*BW_ACCU-1:0] e_above;
        logic [ROWS*BW_ACT-1:0]  e_act;
        logic [COLS-1:0]         e_colv;
        forever begin
            @(negedge clk);
            n = cyc;
            if (n < NCYC) begin
                if (reset) begin
                    e_ph = P_IDLE; e_load = 1'b0; e_above = '0; e_act = '0; e_colv = '0;
                end else begin
                    e_ph = exp_ph[n]; e_load = exp_load[n]; e_above = exp_above[n];
                    e_act = exp_act[n]; e_colv = exp_colv[n];
                end
                check("clear_weight", arr_clear_weight, e_ph == P_CLEAR);
                check("wet_ready",    wet_ready,        e_ph == P_LOAD);
                check("act_ready",    act_ready,        e_ph == P_STREAM);
                check("mac_enable",   arr_mac_enable,   e_ph == P_STREAM || e_ph == P_FLUSH);
                check("busy",         busy,             e_ph != P_IDLE);
                check("done",         done,             e_ph == P_DONE);
                check("load_weight",  arr_load_weight,  e_load);
                check("above_out",    arr_above_out,    e_above);
                check("act_out",      arr_act_out,      e_act);
                check("col_valid",    col_valid_out,    e_colv);
                tr_load[n] = arr_load_weight; tr_mac[n] = arr_mac_enable;
                tr_clear[n] = arr_clear_weight; tr_busy[n] = busy; tr_done[n] = done;
                tr_above[n] = arr_above_out; tr_act[n] = arr_act_out; tr_colv[n] = col_valid_out;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic put_wet(input logic [COLS*BW_WET-1:0] d);
        int k;
        wet_valid = 1'b1; wet_data = d; k = 0;
        while (!wet_ready && k < 64) begin step(); k++; end
        check("wet_ready_wait", k < 64, 1'b1);
        step();
        wet_valid = 1'b0;
    endtask

    task automatic put_act(input logic [ROWS*BW_ACT-1:0] d);
        int k;
        act_valid = 1'b1; act_data = d; k = 0;
        while (!act_ready && k < 64) begin step(); k++; end
        check("act_ready_wait", k < 64, 1'b1);
        step();
        act_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int k;
        k = 0; dc = -1;
        while (k < 100 && dc < 0) begin
            if (done) dc = cyc;
            else begin step(); k++; end
        end
        check("done_wait", dc >= 0, 1'b1);
        step();
    endtask

    task automatic start_tile(input logic [15:0] nv, output int t);
        t = cyc; start = 1'b1; num_vec = nv;
        step();
        start = 1'b0;
    endtask

    // ---------------- directed tiles ----------------
    initial begin
        int t, dc, cnt, r0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Tile A: weights 1..16 bottom row first, 3 vectors with one bubble.
        start_tile(16'd3, t);
        fork
            begin
                put_wet(32'h04030201); put_wet(32'h08070605);
                put_wet(32'h0C0B0A09); put_wet(32'h100F0E0D);
            end
            begin
                put_act(32'h04030201);
                step();
                put_act(32'hF010807F);
                put_act(32'h11223344);
            end
        join
        wait_done(dc);
        cnt = 0;
        for (int i = t; i < t + 12; i++) cnt += int'(tr_load[i]);
        check("a_load_cycles", cnt, 4);
        check("a_clear_at_t1", tr_clear[t+1], 1'b1);
        check("a_above_first", tr_above[t+3], 128'h00000004_00000003_00000002_00000001);
        check("a_above_last",  tr_above[t+6], 128'h00000010_0000000F_0000000E_0000000D);
        for (int r = 0; r < ROWS; r++)
            check("a_v1_row", tr_act[t+7+K*r][r*BW_ACT +: BW_ACT], r + 1);
        check("a_colv0_0", tr_colv[t+7+3*K][0],   1'b1);
        check("a_colv0_1", tr_colv[t+7+3*K+1][0], 1'b0);
        check("a_colv0_2", tr_colv[t+7+3*K+2][0], 1'b1);
        check("a_colv0_3", tr_colv[t+7+3*K+3][0], 1'b1);
`ifdef SYSTOLIC_FEEDER_SKEW_EN
        check("a_colv3_at_s7",  tr_colv[t+13][3], 1'b1);
        check("a_colv3_before", tr_colv[t+12][3], 1'b0);
        check("a_done_cycle", dc - t, 17);
`else
        check("a_colv3_at_s4",  tr_colv[t+10][3], 1'b1);
        check("a_colv3_before", tr_colv[t+9][3],  1'b0);
        check("a_done_cycle", dc - t, 14);
`endif

        // Tile B: num_vec = 0, negative weights; no MAC cycle at all.
        start_tile(16'd0, t);
        put_wet(32'h017F80FF); put_wet(32'h00000000);
        put_wet(32'h80808080); put_wet(32'h7F7F7F7F);
        wait_done(dc);
        cnt = 0;
        for (int i = t; i < t + 9; i++) cnt += int'(tr_mac[i]);
        check("b_mac_cycles", cnt, 0);
        check("b_above_sext", tr_above[t+3], 128'h00000001_0000007F_FFFFFF80_FFFFFFFF);
        check("b_done_cycle", dc - t, 6);

        // Tile C: weight gap plus a stray start (num_vec 9) during LOAD.
        start_tile(16'd2, t);
        fork
            begin
                put_wet(32'h01010101); put_wet(32'h02020202);
                step();
                put_wet(32'h03030303); put_wet(32'h04040404);
            end
            begin
                repeat (2) step();
                start = 1'b1; num_vec = 16'd9;
                step();
                start = 1'b0; num_vec = 16'd2;
            end
            begin
                put_act(32'h05060708); put_act(32'hFFFEFDFC);
            end
        join
        wait_done(dc);
        check("c_load_gap",  tr_load[t+5], 1'b0);
        check("c_above_gap", tr_above[t+5], 128'h0);
        check("c_done_cycle", dc - t, 9 + D);
        cnt = 0;
        for (int i = t; i < dc + 3; i++) cnt += int'(tr_done[i]);
        check("c_done_pulses", cnt, 1);

        // Tile D: reset while streaming.
        start_tile(16'd5, t);
        fork
            begin
                put_wet(32'h11111111); put_wet(32'h22222222);
                put_wet(32'h33333333); put_wet(32'h44444444);
            end
            begin
                put_act(32'h0A0B0C0D); put_act(32'h01020304);
            end
        join
        r0 = cyc;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        check("d_mac_before_reset", tr_mac[r0-1], 1'b1);
        check("d_mac_after_reset",  tr_mac[r0+1], 1'b0);
        check("d_busy_after_reset", tr_busy[r0+1], 1'b0);
        check("d_act_after_reset",  tr_act[r0+1], 32'h0);
        check("d_colv_after_reset", tr_colv[r0+1], 4'h0);
        step();

        // Tile E: clean restart after reset.
        start_tile(16'd1, t);
        fork
            begin
                put_wet(32'h01020304); put_wet(32'h05060708);
                put_wet(32'h090A0B0C); put_wet(32'h0D0E0F10);
            end
            put_act(32'h7F80FF01);
        join
        wait_done(dc);
        check("e_idle_at_start", tr_busy[t], 1'b0);
        check("e_clear_at_t1",   tr_clear[t+1], 1'b1);
        check("e_done_cycle",    dc - t, 7 + D);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
